// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the FP16 datapath (multiplier and adder).
// Holds field widths, canonical encodings, the unpacked struct and operand classification.
package fp16_pkg;

    localparam int EXP_WIDTH = 5;
    localparam int MAN_WIDTH = 10;
    localparam int EXP_BIAS = 15;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_POS_INF = 16'h7C00;

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [MAN_WIDTH-1:0] man;
    } fp16_t;

    typedef enum logic [1:0] {
        CL_ZERO = 2'd0,
        CL_NORM = 2'd1,
        CL_INF  = 2'd2,
        CL_NAN  = 2'd3
    } fp_class_e;

    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_ZERO = 2'd1,
        SP_INF  = 2'd2,
        SP_NAN  = 2'd3
    } special_e;

    // Subnormal encodings classify as zero so they flush on input.
    function automatic fp_class_e fp16_classify(input fp16_t x);
        fp_class_e c;
        if (x.exp == '0) begin
            c = CL_ZERO;
        end else if (x.exp == '1) begin
            c = (x.man == '0) ? CL_INF : CL_NAN;
        end else begin
            c = CL_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fp16_normalize_round.sv
// Normalizes a 22-bit significand product, rounds to nearest-even and packs a binary16 result.
// Purely combinational so the caller decides where the output register sits.
module fp16_normalize_round
    import fp16_pkg::*;
(
    input  logic        sign,
    input  logic [7:0]  exp_sum,
    input  logic [21:0] prod,
    input  special_e    special,
    output logic [15:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);

    logic [9:0]         man_s;
    logic               guard_s;
    logic               rnd_s;
    logic               sticky_s;
    logic               round_up_s;
    logic [10:0]        man_rnd_s;
    logic signed [9:0]  exp_fin_s;

    // Select the normalized window, round, and resolve special/range cases.
    always_comb begin
        man_s      = prod[21] ? prod[20:11] : prod[19:10];
        guard_s    = prod[21] ? prod[10] : prod[9];
        rnd_s      = prod[21] ? prod[9] : prod[8];
        sticky_s   = prod[21] ? (|prod[8:0]) : (|prod[7:0]);
        round_up_s = guard_s & (rnd_s | sticky_s | man_s[0]);
        man_rnd_s  = {1'b0, man_s} + {10'd0, round_up_s};
        // exp_sum is two's complement; a rounding carry leaves the mantissa at zero.
        exp_fin_s  = $signed({{2{exp_sum[7]}}, exp_sum}) + $signed({9'd0, prod[21]})
                   + $signed({9'd0, man_rnd_s[10]});
        result     = 16'h0000;
        overflow   = 1'b0;
        underflow  = 1'b0;
        invalid    = 1'b0;
        case (special)
            SP_NAN: begin
                result  = FP16_QNAN;
                invalid = 1'b1;
            end
            SP_INF: begin
                result = FP16_POS_INF | {sign, 15'd0};
            end
            SP_ZERO: begin
                result = {sign, 15'd0};
            end
            SP_NONE: begin
                if (exp_fin_s >= 10'sd31) begin
                    result   = FP16_POS_INF | {sign, 15'd0};
                    overflow = 1'b1;
                end else if (exp_fin_s <= 10'sd0) begin
                    result    = {sign, 15'd0};
                    underflow = 1'b1;
                end else begin
                    result = {sign, exp_fin_s[4:0], man_rnd_s[9:0]};
                end
            end
            default: begin
                result = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/fp16_multiplier_pipe.sv
// Three-stage binary16 multiplier: unpack/classify, significand multiply, normalize/round/pack.
// en stalls every register; a valid bit travels alongside each stage's payload.
module fp16_multiplier_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int EXP_WIDTH  = 5,
    parameter int MAN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  invalid
);
    import fp16_pkg::*;

    localparam int SIG_WIDTH  = MAN_WIDTH + 1;
    localparam int PROD_WIDTH = 2 * SIG_WIDTH;

    fp16_t                 a_f_s;
    fp16_t                 b_f_s;
    fp_class_e             cls_a_s;
    fp_class_e             cls_b_s;
    special_e              special_s;
    logic [7:0]            exp_sum_s;
    logic [SIG_WIDTH-1:0]  sig_a_s;
    logic [SIG_WIDTH-1:0]  sig_b_s;

    logic                  s1_valid_r;
    logic                  s1_sign_r;
    logic [7:0]            s1_exp_r;
    logic [SIG_WIDTH-1:0]  s1_sig_a_r;
    logic [SIG_WIDTH-1:0]  s1_sig_b_r;
    special_e              s1_special_r;

    logic                  s2_valid_r;
    logic                  s2_sign_r;
    logic [7:0]            s2_exp_r;
    logic [PROD_WIDTH-1:0] s2_prod_r;
    special_e              s2_special_r;

    logic [15:0]           nr_result_s;
    logic                  nr_overflow_s;
    logic                  nr_underflow_s;
    logic                  nr_invalid_s;

    // Stage 1 combinational unpack, exponent sum and special-case priority.
    always_comb begin
        a_f_s     = a;
        b_f_s     = b;
        cls_a_s   = fp16_classify(a_f_s);
        cls_b_s   = fp16_classify(b_f_s);
        exp_sum_s = {{(8-EXP_WIDTH){1'b0}}, a_f_s.exp} + {{(8-EXP_WIDTH){1'b0}}, b_f_s.exp}
                  - 8'(EXP_BIAS);
        sig_a_s   = {1'b1, a_f_s.man};
        sig_b_s   = {1'b1, b_f_s.man};
        if ((cls_a_s == CL_NAN) || (cls_b_s == CL_NAN)
            || ((cls_a_s == CL_INF) && (cls_b_s == CL_ZERO))
            || ((cls_b_s == CL_INF) && (cls_a_s == CL_ZERO))) begin
            special_s = SP_NAN;
        end else if ((cls_a_s == CL_INF) || (cls_b_s == CL_INF)) begin
            special_s = SP_INF;
        end else if ((cls_a_s == CL_ZERO) || (cls_b_s == CL_ZERO)) begin
            special_s = SP_ZERO;
        end else begin
            special_s = SP_NONE;
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_r   <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_exp_r     <= 8'd0;
            s1_sig_a_r   <= '0;
            s1_sig_b_r   <= '0;
            s1_special_r <= SP_NONE;
        end else if (en) begin
            s1_valid_r   <= in_valid;
            s1_sign_r    <= a_f_s.sign ^ b_f_s.sign;
            s1_exp_r     <= exp_sum_s;
            s1_sig_a_r   <= sig_a_s;
            s1_sig_b_r   <= sig_b_s;
            s1_special_r <= special_s;
        end
    end

    // Stage 2 register: full-width significand product.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_r   <= 1'b0;
            s2_sign_r    <= 1'b0;
            s2_exp_r     <= 8'd0;
            s2_prod_r    <= '0;
            s2_special_r <= SP_NONE;
        end else if (en) begin
            s2_valid_r   <= s1_valid_r;
            s2_sign_r    <= s1_sign_r;
            s2_exp_r     <= s1_exp_r;
            s2_prod_r    <= PROD_WIDTH'(s1_sig_a_r) * PROD_WIDTH'(s1_sig_b_r);
            s2_special_r <= s1_special_r;
        end
    end

    fp16_normalize_round u_norm (
        .sign      (s2_sign_r),
        .exp_sum   (s2_exp_r),
        .prod      (s2_prod_r),
        .special   (s2_special_r),
        .result    (nr_result_s),
        .overflow  (nr_overflow_s),
        .underflow (nr_underflow_s),
        .invalid   (nr_invalid_s)
    );

    // Output register; bubbles leave the last product and flags in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid_r;
            if (s2_valid_r) begin
                result    <= DATA_WIDTH'(nr_result_s);
                overflow  <= nr_overflow_s;
                underflow <= nr_underflow_s;
                invalid   <= nr_invalid_s;
            end
        end
    end

endmodule

// File: tb/tb_fp16_multiplier_pipe.sv
// Directed bench for fp16_multiplier_pipe: hand-computed products, rounding, specials,
// stall behaviour and mid-stream reset, checked with immediate assertions.
module tb_fp16_multiplier_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        out_valid;
    logic [15:0] result;
    logic        overflow;
    logic        underflow;
    logic        invalid;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fp16_multiplier_pipe #(
        .DATA_WIDTH (16),
        .EXP_WIDTH  (5),
        .MAN_WIDTH  (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    function automatic logic [19:0] vec(input logic v, input logic o, input logic u,
                                        input logic i, input logic [15:0] r);
        return {v, o, u, i, r};
    endfunction

    task automatic check(input string tag, input logic [19:0] expv);
        logic [19:0] obs;
        obs = {out_valid, overflow, underflow, invalid, result};
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed={v,o,u,i,res}=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic v);
        a = va;
        b = vb;
        in_valid = v;
    endtask

    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic [19:0] expv);
        drive(va, vb, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check(tag, expv);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 reset = 1'b0;
        #1 check("reset_state", vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
        tick();
        tick();
        reset = 1'b1;
        tick();

        run_op("mul_3x2", 16'h4200, 16'h4000, vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h4600));
        tick();
        check("bubble_hold", vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h4600));
        run_op("mul_neg", 16'h3E00, 16'hC000, vec(1'b1, 1'b0, 1'b0, 1'b0, 16'hC200));
        run_op("tie_even", 16'h3E00, 16'h3C01, vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h3E02));
        run_op("round_dn", 16'h3C01, 16'h3C01, vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h3C02));
        run_op("overflow", 16'h7BFF, 16'h4000, vec(1'b1, 1'b1, 1'b0, 1'b0, 16'h7C00));
        run_op("underflow", 16'h0400, 16'h0400, vec(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000));
        run_op("inf_x_zero", 16'h7C00, 16'h0000, vec(1'b1, 1'b0, 1'b0, 1'b1, 16'h7E00));
        run_op("nan_in", 16'h7E00, 16'h3C00, vec(1'b1, 1'b0, 1'b0, 1'b1, 16'h7E00));
        run_op("inf_x_neg", 16'h7C00, 16'hC000, vec(1'b1, 1'b0, 1'b0, 1'b0, 16'hFC00));
        run_op("negzero", 16'h8000, 16'h4000, vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h8000));
        run_op("subn_ftz", 16'h0001, 16'h4000, vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000));
        run_op("rnd_carry_ovf", 16'h79A8, 16'h3DA8, vec(1'b1, 1'b1, 1'b0, 1'b0, 16'h7C00));
        run_op("rnd_carry", 16'h3DA8, 16'h3DA8, vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h4000));

        // Five-pair stream with a two-cycle stall after the second pair.
        drive(16'h4200, 16'h4000, 1'b1);
        tick();
        drive(16'h3E00, 16'hC000, 1'b1);
        tick();
        check("stream_pre", vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h4000));
        en = 1'b0;
        drive(16'h5555, 16'h5555, 1'b1);
        tick();
        check("stall_1", vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h4000));
        tick();
        check("stall_2", vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h4000));
        en = 1'b1;
        drive(16'h3C00, 16'h4000, 1'b1);
        tick();
        check("stream_p1", vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h4600));
        drive(16'h4000, 16'h4000, 1'b1);
        tick();
        check("stream_p2", vec(1'b1, 1'b0, 1'b0, 1'b0, 16'hC200));
        en = 1'b0;
        drive(16'h5555, 16'h5555, 1'b1);
        tick();
        check("stall_hold", vec(1'b1, 1'b0, 1'b0, 1'b0, 16'hC200));
        en = 1'b1;
        drive(16'h4200, 16'h4200, 1'b1);
        tick();
        check("stream_p3", vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h4000));
        in_valid = 1'b0;
        tick();
        check("stream_p4", vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h4400));
        tick();
        check("stream_p5", vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h4880));
        tick();
        check("stream_end", vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h4880));

        // Reset with operands in flight.
        drive(16'h4200, 16'h4000, 1'b1);
        tick();
        drive(16'h4000, 16'h4000, 1'b1);
        tick();
        drive(16'h3C00, 16'h4000, 1'b1);
        tick();
        check("rst_pre", vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h4600));
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check("rst_async", vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_flush", vec(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000));
        end
        run_op("post_rst", 16'h4200, 16'h4000, vec(1'b1, 1'b0, 1'b0, 1'b0, 16'h4600));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
